// File: rtl/stripe_pingpong_ctrl_if.sv
// Bus between the 8x8 block producer, the stripe buffer and the raster reader.
// Master drives producer/raster requests; slave is the ping-pong controller.
interface stripe_pingpong_ctrl_if #(
    parameter int N     = 2,
    parameter int X_RES = 2160
);
    localparam int BLKS       = X_RES / 8;
    localparam int BLK_BEATS  = 64 / N;
    localparam int LINE_BEATS = X_RES / N;
    localparam int BLK_W      = $clog2(BLKS);
    localparam int WBEAT_W    = $clog2(BLK_BEATS);
    localparam int RBEAT_W    = $clog2(LINE_BEATS);

    logic               blk_valid;
    logic               blk_sob;
    logic               blk_eob;
    logic               blk_sof;
    logic               blk_ready;
    logic               wr_en;
    logic               wr_bank;
    logic [BLK_W-1:0]   wr_blk;
    logic [WBEAT_W-1:0] wr_beat;
    logic               rd_req;
    logic               rd_frame;
    logic               rd_en;
    logic               rd_bank;
    logic [2:0]         rd_line;
    logic [RBEAT_W-1:0] rd_beat;
    logic               underflow;
    logic               proto_err;

    modport master (
        output blk_valid, blk_sob, blk_eob, blk_sof,
        output rd_req, rd_frame,
        input  blk_ready, wr_en, wr_bank, wr_blk, wr_beat,
        input  rd_en, rd_bank, rd_line, rd_beat,
        input  underflow, proto_err
    );

    modport slave (
        input  blk_valid, blk_sob, blk_eob, blk_sof,
        input  rd_req, rd_frame,
        output blk_ready, wr_en, wr_bank, wr_blk, wr_beat,
        output rd_en, rd_bank, rd_line, rd_beat,
        output underflow, proto_err
    );
endinterface

// File: rtl/stripe_pingpong_ctrl.sv
// Ping-pong stripe buffer sequencer: block writes into the non-full bank,
// raster line reads from the full bank, with framing/underflow pulses.
module stripe_pingpong_ctrl #(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  logic                  clk,
    input  logic                  rst,
    stripe_pingpong_ctrl_if.slave bus
);
    localparam int BLKS       = X_RES / 8;
    localparam int BLK_BEATS  = 64 / N;
    localparam int LINE_BEATS = X_RES / N;
    localparam int BLK_W      = $clog2(BLKS);
    localparam int WBEAT_W    = $clog2(BLK_BEATS);
    localparam int RBEAT_W    = $clog2(LINE_BEATS);

    localparam logic [BLK_W-1:0]   LAST_BLK   = BLK_W'(BLKS - 1);
    localparam logic [WBEAT_W-1:0] LAST_WBEAT = WBEAT_W'(BLK_BEATS - 1);
    localparam logic [RBEAT_W-1:0] LAST_RBEAT = RBEAT_W'(LINE_BEATS - 1);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_BLK  = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_LINE = 1'b1;

    // Stripe geometry must tile into whole blocks and whole beats.
    if ((X_RES % 8) != 0 || (X_RES % N) != 0 ||
        (Y_RES % 8) != 0 || (64 % N) != 0) begin : g_bad_geometry
        $error("stripe_pingpong_ctrl: incompatible X_RES/Y_RES/N");
    end

    logic [1:0]         full_q, full_d;
    logic [0:0]         wst_q, wst_d;
    logic               wr_bank_q, wr_bank_d;
    logic [BLK_W-1:0]   wr_blk_q, wr_blk_d;
    logic [WBEAT_W-1:0] wr_beat_q, wr_beat_d;
    logic               perr_q, perr_d;
    logic [0:0]         rst_q, rst_d;
    logic               rd_bank_q, rd_bank_d;
    logic [2:0]         rd_line_q, rd_line_d;
    logic [RBEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic               frm_q, frm_d;
    logic               unf_q, unf_d;

    logic               ready;
    logic               sob_ok;
    logic               beat_in;
    logic               wr_en;
    logic [WBEAT_W-1:0] cur_beat;
    logic [BLK_W-1:0]   cur_blk;
    logic               set_full;
    logic               clr_full;
    logic               rd_last;

    // Qualify producer beats; sob and sof take effect on the accepting beat.
    always_comb begin
        ready    = !full_q[wr_bank_q] && (wst_q == W_IDLE);
        sob_ok   = ready && bus.blk_valid && bus.blk_sob;
        beat_in  = (wst_q == W_BLK) && bus.blk_valid && !bus.blk_sob;
        wr_en    = sob_ok || beat_in;
        cur_beat = (wst_q == W_IDLE) ? '0 : wr_beat_q;
        cur_blk  = (sob_ok && bus.blk_sof) ? '0 : wr_blk_q;
    end

    // Write sequencing: block framing checks and stripe completion.
    always_comb begin
        wst_d     = wst_q;
        wr_bank_d = wr_bank_q;
        wr_blk_d  = wr_blk_q;
        wr_beat_d = wr_beat_q;
        perr_d    = 1'b0;
        set_full  = 1'b0;
        if (wr_en) begin
            wr_beat_d = cur_beat + 1'b1;
        end
        if (bus.blk_valid && (wst_q == W_BLK) && bus.blk_sob) begin
            perr_d = 1'b1;
        end
        if (bus.blk_valid && (wst_q == W_IDLE) && !bus.blk_sob) begin
            perr_d = 1'b1;
        end
        if (sob_ok) begin
            wst_d = W_BLK;
            if (bus.blk_sof) begin
                wr_blk_d = '0;
                if (wr_blk_q != '0) begin
                    perr_d = 1'b1;
                end
            end
        end
        if (wr_en && bus.blk_eob) begin
            wst_d = W_IDLE;
            if (cur_beat != LAST_WBEAT) begin
                perr_d = 1'b1;
            end else if (cur_blk == LAST_BLK) begin
                set_full  = 1'b1;
                wr_bank_d = ~wr_bank_q;
                wr_blk_d  = '0;
            end else begin
                wr_blk_d = cur_blk + 1'b1;
            end
        end
    end

    // Read sequencing: one line per request, stripe release after line 7.
    always_comb begin
        rst_d     = rst_q;
        rd_bank_d = rd_bank_q;
        rd_line_d = rd_line_q;
        rd_beat_d = rd_beat_q;
        frm_d     = frm_q;
        unf_d     = 1'b0;
        clr_full  = 1'b0;
        rd_last   = (rst_q == R_LINE) && (rd_beat_q == LAST_RBEAT);
        if (rst_q == R_LINE) begin
            unf_d     = bus.rd_req;
            rd_beat_d = rd_beat_q + 1'b1;
            if (rd_last) begin
                rst_d     = R_IDLE;
                rd_beat_d = '0;
                if (frm_q || bus.rd_frame) begin
                    rd_line_d = 3'd0;
                    frm_d     = 1'b0;
                end else if (rd_line_q == 3'd7) begin
                    clr_full  = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_line_d = 3'd0;
                end else begin
                    rd_line_d = rd_line_q + 3'd1;
                end
            end else if (bus.rd_frame) begin
                frm_d = 1'b1;
            end
        end else begin
            if (bus.rd_frame) begin
                rd_line_d = 3'd0;
                frm_d     = 1'b0;
            end
            if (bus.rd_req) begin
                if (full_q[rd_bank_q]) begin
                    rst_d = R_LINE;
                end else begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    // Bank occupancy: set and clear land on different banks in one cycle.
    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Write-side and bank-occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wst_q     <= W_IDLE;
            wr_bank_q <= 1'b0;
            wr_blk_q  <= '0;
            wr_beat_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            wst_q     <= wst_d;
            wr_bank_q <= wr_bank_d;
            wr_blk_q  <= wr_blk_d;
            wr_beat_q <= wr_beat_d;
            perr_q    <= perr_d;
        end
    end

    // Read-side state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q     <= R_IDLE;
            rd_bank_q <= 1'b0;
            rd_line_q <= 3'd0;
            rd_beat_q <= '0;
            frm_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            rst_q     <= rst_d;
            rd_bank_q <= rd_bank_d;
            rd_line_q <= rd_line_d;
            rd_beat_q <= rd_beat_d;
            frm_q     <= frm_d;
            unf_q     <= unf_d;
        end
    end

    assign bus.blk_ready = ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.wr_blk    = cur_blk;
    assign bus.wr_beat   = cur_beat;
    assign bus.rd_en     = (rst_q == R_LINE);
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_line   = rd_line_q;
    assign bus.rd_beat   = rd_beat_q;
    assign bus.underflow = unf_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_stripe_pingpong_ctrl.sv
// Testbench for stripe_pingpong_ctrl: directed scenarios plus randomized
// producer/raster traffic against a behavioural transaction model.
module tb_stripe_pingpong_ctrl;
    localparam int N          = 2;
    localparam int X_RES      = 2160;
    localparam int Y_RES      = 1200;
    localparam int BLKS       = X_RES / 8;
    localparam int BLK_BEATS  = 64 / N;
    localparam int LINE_BEATS = X_RES / N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stripe_pingpong_ctrl_if #(.N(N), .X_RES(X_RES)) bus ();

    stripe_pingpong_ctrl #(
        .N(N), .X_RES(X_RES), .Y_RES(Y_RES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // model: bank occupancy, write position, read position
    bit [1:0] m_full;
    int       m_wbank, m_wblk, m_beat;
    bit       m_inblk;
    int       m_rbank, m_line, m_rleft;
    bit       m_fp, m_unf, m_perr;

    int obs_wr, obs_rd, obs_perr, obs_stall;
    bit hold;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 2'b00;
        m_wbank = 0;
        m_wblk  = 0;
        m_beat  = 0;
        m_inblk = 0;
        m_rbank = 0;
        m_line  = 0;
        m_rleft = 0;
        m_fp    = 0;
        m_unf   = 0;
        m_perr  = 0;
    endtask

    task automatic idle();
        bus.blk_valid = 1'b0;
        bus.blk_sob   = 1'b0;
        bus.blk_eob   = 1'b0;
        bus.blk_sof   = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_frame  = 1'b0;
    endtask

    // one clock: check outputs mid-cycle, advance model, move past edge
    task automatic step();
        bit rdy, acc, we, rena;
        int beat, eblk, setb, clrb;
        logic [26:0] gw, ew;
        logic [20:0] gr, er;
        #4;
        if (rst) model_reset();
        rdy  = !m_full[m_wbank] && !m_inblk;
        acc  = rdy && bus.blk_valid && bus.blk_sob;
        we   = acc || (m_inblk && bus.blk_valid && !bus.blk_sob);
        beat = acc ? 0 : m_beat;
        eblk = (acc && bus.blk_sof) ? 0 : m_wblk;
        rena = (m_rleft > 0);
        gw = {bus.blk_ready, bus.wr_en, bus.wr_bank,
              16'(bus.wr_blk),
              8'(bus.wr_en ? bus.wr_beat : '0)};
        ew = {rdy, we, 1'(m_wbank), 16'(eblk),
              8'(we ? beat : 0)};
        gr = {bus.rd_en, bus.rd_bank, bus.rd_line,
              16'(bus.rd_en ? bus.rd_beat : '0)};
        er = {rena, 1'(m_rbank), 3'(m_line),
              16'(rena ? LINE_BEATS - m_rleft : 0)};
        chk("wr", 64'(gw), 64'(ew));
        chk("rd", 64'(gr), 64'(er));
        chk("pulse", 64'({bus.underflow, bus.proto_err}),
            64'({m_unf, m_perr}));
        obs_wr    += int'(bus.wr_en);
        obs_rd    += int'(bus.rd_en);
        obs_perr  += int'(bus.proto_err);
        obs_stall += int'(bus.blk_valid && bus.blk_sob &&
                          !bus.blk_ready);
        if (!rst) begin
            setb = -1;
            clrb = -1;
            m_perr = bus.blk_valid &&
                     (m_inblk ? bus.blk_sob : !bus.blk_sob);
            if (acc && bus.blk_sof) begin
                if (m_wblk != 0) m_perr = 1;
                m_wblk = 0;
            end
            if (acc) m_inblk = 1;
            if (we) m_beat = beat + 1;
            if (we && bus.blk_eob) begin
                m_inblk = 0;
                if (beat != BLK_BEATS - 1) m_perr = 1;
                else if (m_wblk == BLKS - 1) begin
                    setb    = m_wbank;
                    m_wblk  = 0;
                    m_wbank = 1 - m_wbank;
                end else m_wblk++;
            end
            m_unf = bus.rd_req && (rena || !m_full[m_rbank]);
            if (rena) begin
                if (bus.rd_frame) m_fp = 1;
                m_rleft--;
                if (m_rleft == 0) begin
                    if (m_fp) begin
                        m_line = 0;
                        m_fp   = 0;
                    end else if (m_line == 7) begin
                        clrb    = m_rbank;
                        m_rbank = 1 - m_rbank;
                        m_line  = 0;
                    end else m_line++;
                end
            end else begin
                if (bus.rd_frame) begin
                    m_line = 0;
                    m_fp   = 0;
                end
                if (bus.rd_req && m_full[m_rbank])
                    m_rleft = LINE_BEATS;
            end
            if (setb >= 0) m_full[setb] = 1'b1;
            if (clrb >= 0) m_full[clrb] = 1'b0;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic send_block(bit sof, int nbeats, int eob_at);
        for (int i = 0; i < nbeats; i++) begin
            bus.blk_valid = 1'b1;
            bus.blk_sob   = (i == 0);
            bus.blk_sof   = sof && (i == 0);
            bus.blk_eob   = (i == eob_at);
            step();
        end
    endtask

    task automatic rand_cycle(int rd_div);
        if (!m_inblk) begin
            if (hold || $urandom_range(3) == 0) begin
                bus.blk_valid = 1'b1;
                bus.blk_sob   = 1'b1;
            end
        end else if ($urandom_range(7) != 0) begin
            bus.blk_valid = 1'b1;
            bus.blk_eob   = (m_beat == BLK_BEATS - 1);
        end
        hold = bus.blk_valid && bus.blk_sob && m_full[m_wbank];
        if (m_rleft == 0)
            bus.rd_req = ($urandom_range(rd_div - 1) == 0);
        else
            bus.rd_req = ($urandom_range(499) == 0);
        bus.rd_frame = ($urandom_range(9999) == 0);
        step();
    endtask

    initial begin
        int p0;
        idle();
        model_reset();
        hold = 0;
        obs_wr = 0; obs_rd = 0; obs_perr = 0; obs_stall = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 64'(bus.blk_ready), 64'(1));
        chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
        chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("rst_banks", 64'({bus.wr_bank, bus.rd_bank}), 64'(0));
        chk("rst_pulse", 64'({bus.underflow, bus.proto_err}), 64'(0));

        // read with no data
        bus.rd_req = 1'b1;
        step();
        chk("t4_unf", 64'(bus.underflow), 64'(1));
        chk("t4_rd_en", 64'(bus.rd_en), 64'(0));
        step();
        chk("t4_unf_end", 64'(bus.underflow), 64'(0));
        chk("t4_line", 64'(bus.rd_line), 64'(0));

        // single block
        obs_wr = 0;
        send_block(1'b1, BLK_BEATS, BLK_BEATS - 1);
        chk("t1_beats", 64'(obs_wr), 64'(BLK_BEATS));
        chk("t1_blk", 64'(bus.wr_blk), 64'(1));
        chk("t1_bank", 64'(bus.wr_bank), 64'(0));

        // framing violations
        send_block(1'b0, 21, 20);
        chk("t5_eob_err", 64'(bus.proto_err), 64'(1));
        chk("t5_blk_keep", 64'(bus.wr_blk), 64'(1));
        for (int b = 0; b < 4; b++)
            send_block(1'b0, BLK_BEATS, BLK_BEATS - 1);
        chk("t5_blk5", 64'(bus.wr_blk), 64'(5));
        p0 = obs_perr;
        send_block(1'b1, BLK_BEATS, BLK_BEATS - 1);
        step();
        chk("t5_sof_err", 64'(obs_perr - p0), 64'(1));
        chk("t5_sof_blk", 64'(bus.wr_blk), 64'(1));
        bus.blk_valid = 1'b1;
        step();
        chk("t5_nosob", 64'(bus.proto_err), 64'(1));
        send_block(1'b0, 5, 99);
        bus.blk_valid = 1'b1;
        bus.blk_sob   = 1'b1;
        step();
        chk("t5_sob_in_blk", 64'(bus.proto_err), 64'(1));
        for (int i = 5; i < BLK_BEATS; i++) begin
            bus.blk_valid = 1'b1;
            bus.blk_eob   = (i == BLK_BEATS - 1);
            step();
        end
        chk("t5_blk_resume", 64'(bus.wr_blk), 64'(2));

        // fresh start: fill bank 0, read 7 lines
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_wr = 0;
        obs_rd = 0;
        for (int b = 0; b < BLKS; b++)
            send_block(b == 0, BLK_BEATS, BLK_BEATS - 1);
        chk("t2_wr_beats", 64'(obs_wr), 64'(BLKS * BLK_BEATS));
        chk("t2_wr_bank", 64'(bus.wr_bank), 64'(1));
        chk("t2_ready", 64'(bus.blk_ready), 64'(1));
        for (int l = 0; l < 7; l++) begin
            chk("t2_line", 64'(bus.rd_line), 64'(l));
            bus.rd_req = 1'b1;
            step();
            repeat (LINE_BEATS) step();
        end
        chk("t2_rd_beats", 64'(obs_rd), 64'(7 * LINE_BEATS));

        // bank 1 completes on the same cycle bank 0 drains
        for (int b = 0; b < BLKS - 1; b++)
            send_block(b == 0, BLK_BEATS, BLK_BEATS - 1);
        send_block(1'b0, BLK_BEATS - 1, 99);
        bus.rd_req = 1'b1;
        step();
        repeat (LINE_BEATS - 1) step();
        bus.blk_valid = 1'b1;
        bus.blk_eob   = 1'b1;
        step();
        chk("t6_ready", 64'(bus.blk_ready), 64'(1));
        chk("t6_banks", 64'({bus.wr_bank, bus.rd_bank}), 64'(1));
        chk("t6_line", 64'(bus.rd_line), 64'(0));
        chk("t2_rd_total", 64'(obs_rd), 64'(8 * LINE_BEATS));
        bus.rd_req = 1'b1;
        step();
        chk("t6_no_unf", 64'(bus.underflow), 64'(0));
        chk("t6_rd_en", 64'(bus.rd_en), 64'(1));

        // random traffic: slow reader first so both banks fill
        obs_stall = 0;
        repeat (20000) rand_cycle(3000);
        chk("t3_stall", 64'(obs_stall > 0), 64'(1));
        repeat (18000) rand_cycle(4);

        // reset in the middle of traffic
        repeat (37) rand_cycle(4);
        rst  = 1'b1;
        hold = 0;
        step();
        rst = 1'b0;
        chk("midrst_ready", 64'(bus.blk_ready), 64'(1));
        chk("midrst_blk", 64'(bus.wr_blk), 64'(0));
        chk("midrst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("midrst_banks", 64'({bus.wr_bank, bus.rd_bank}), 64'(0));
        repeat (200) rand_cycle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
